// File: rtl/pcs_pkg.sv
// Shared constants and types for the PCS receive path: sync headers,
// descrambler taps, lock FSM encoding and default lock parameters.
package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // x^58 + x^39 + 1
  localparam int SCR_TAP_A = 39;
  localparam int SCR_TAP_B = 58;

  localparam int DEF_SH_LOCK_CNT  = 64;
  localparam int DEF_SH_WINDOW    = 1024;
  localparam int DEF_SH_INVLD_MAX = 16;
  localparam int DEF_SLIP_WAIT    = 32;

  typedef enum logic [1:0] {
    ST_LOCK_INIT,
    ST_TEST_SH,
    ST_SLIP_WAIT,
    ST_LOCKED
  } lock_state_e;

  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SYNC_DATA) || (sh == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/pcs_rx_descrambler.sv
// Self-synchronizing 64b/66b descrambler; the history register holds the
// most recent received (scrambled) bits, MSB being the newest.
module pcs_rx_descrambler
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [SCR_TAP_B-1:0]            state;
  logic [DATA_WIDTH+SCR_TAP_B-1:0] hist;

  // hist[SCR_TAP_B+i] is current bit i; hist[j] for j<SCR_TAP_B is older state
  assign hist = {i_data, state};

  always_comb begin
    o_data = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      o_data[i] = i_data[i] ^ hist[i + SCR_TAP_B - SCR_TAP_A] ^ hist[i];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      state <= '0;
    else if (i_en)
      state <= i_data[DATA_WIDTH-1 -: SCR_TAP_B];
  end

endmodule

// File: rtl/pcs_rx_block_sync.sv
// 64b/66b block lock acquisition with gearbox slip control, followed by
// payload descrambling and a single output register stage.
module pcs_rx_block_sync
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,  // only 64 is supported
  parameter int SH_LOCK_CNT  = DEF_SH_LOCK_CNT,
  parameter int SH_WINDOW    = DEF_SH_WINDOW,
  parameter int SH_INVLD_MAX = DEF_SH_INVLD_MAX,
  parameter int SLIP_WAIT    = DEF_SLIP_WAIT
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [1:0]            i_rx_header,
  input  logic                  i_rx_valid,
  output logic                  o_rx_slip,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic [1:0]            o_rx_header,
  output logic                  o_rx_valid,
  output logic                  o_block_lock
);

  localparam int CW = $clog2(SH_WINDOW) + 1;
  localparam int WW = $clog2(SLIP_WAIT + 1);

  lock_state_e           state, state_nxt;
  logic [CW-1:0]         sh_cnt, sh_cnt_nxt;
  logic [CW-1:0]         invld_cnt, invld_cnt_nxt;
  logic [WW-1:0]         wait_cnt, wait_cnt_nxt;
  logic                  slip_nxt;
  logic                  hdr_ok;
  logic [DATA_WIDTH-1:0] descr_data;

  assign hdr_ok = sh_is_valid(i_rx_header);

  pcs_rx_descrambler #(.DATA_WIDTH(DATA_WIDTH)) u_descr (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (i_rx_valid),
    .i_data    (i_rx_data),
    .o_data    (descr_data)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_LOCK_INIT;
      sh_cnt    <= '0;
      invld_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      sh_cnt    <= sh_cnt_nxt;
      invld_cnt <= invld_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sh_cnt_nxt    = sh_cnt;
    invld_cnt_nxt = invld_cnt;
    wait_cnt_nxt  = wait_cnt;
    slip_nxt      = 1'b0;
    case (state)
      ST_LOCK_INIT: begin
        sh_cnt_nxt    = '0;
        invld_cnt_nxt = '0;
        state_nxt     = ST_TEST_SH;
      end
      ST_TEST_SH: begin
        if (i_rx_valid) begin
          if (!hdr_ok) begin
            slip_nxt      = 1'b1;
            sh_cnt_nxt    = '0;
            invld_cnt_nxt = '0;
            wait_cnt_nxt  = '0;
            state_nxt     = ST_SLIP_WAIT;
          end else if (sh_cnt == CW'(SH_LOCK_CNT - 1)) begin
            sh_cnt_nxt    = '0;
            invld_cnt_nxt = '0;
            state_nxt     = ST_LOCKED;
          end else begin
            sh_cnt_nxt = sh_cnt + 1'b1;
          end
        end
      end
      // Free-running on i_clk: the gearbox settles in wall-clock time
      ST_SLIP_WAIT: begin
        if (wait_cnt == WW'(SLIP_WAIT - 1)) begin
          wait_cnt_nxt = '0;
          state_nxt    = ST_TEST_SH;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (i_rx_valid) begin
          // Unlock is checked first so it wins on the last block of a window
          if (!hdr_ok && (invld_cnt == CW'(SH_INVLD_MAX - 1))) begin
            slip_nxt      = 1'b1;
            sh_cnt_nxt    = '0;
            invld_cnt_nxt = '0;
            wait_cnt_nxt  = '0;
            state_nxt     = ST_SLIP_WAIT;
          end else if (sh_cnt == CW'(SH_WINDOW - 1)) begin
            sh_cnt_nxt    = '0;
            invld_cnt_nxt = '0;
          end else begin
            sh_cnt_nxt = sh_cnt + 1'b1;
            if (!hdr_ok)
              invld_cnt_nxt = invld_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_LOCK_INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rx_slip    <= 1'b0;
      o_block_lock <= 1'b0;
      o_rx_valid   <= 1'b0;
      o_rx_data    <= '0;
      o_rx_header  <= '0;
    end else begin
      o_rx_slip    <= slip_nxt;
      o_block_lock <= (state_nxt == ST_LOCKED);
      // o_block_lock still holds the lock state in force when this block was sampled
      o_rx_valid   <= i_rx_valid && o_block_lock;
      if (i_rx_valid) begin
        o_rx_data   <= descr_data;
        o_rx_header <= i_rx_header;
      end
    end
  end

endmodule

// File: doc/pcs_rx_block_sync.md
# pcs_rx_block_sync

Receive-side companion to the PCS transmit path. It takes 66-bit blocks (2-bit sync header plus 64-bit payload) from the GTY RX gearbox and acquires 64b/66b block lock, commanding gearbox bit-slips until lock is achieved. It then self-synchronously descrambles the payload (x^58 + x^39 + 1) and presents header, descrambled payload and lock status to the XGMII decoder downstream.

## Interface
Parameters:
- DATA_WIDTH, 64: payload width per block; only 64 is supported.
- SH_LOCK_CNT, 64: consecutive valid headers required to declare lock.
- SH_WINDOW, 1024: header window length while locked.
- SH_INVLD_MAX, 16: invalid headers within one window that drop lock.
- SLIP_WAIT, 32: cycles of i_clk ignored after each slip pulse (gearbox settling).

Ports:
- i_clk, input, 1: PCS RX clock (GTY RXUSRCLK2).
- i_reset_n, input, 1: asynchronous, active-low reset.
- i_rx_data, input, 64: scrambled payload; bit 0 was received first.
- i_rx_header, input, 2: sync header.
- i_rx_valid, input, 1: block qualifier. Gearbox pause cycles hold it low.
- o_rx_slip, output, 1: one-cycle slip request to the gearbox.
- o_rx_data, output, 64: descrambled payload.
- o_rx_header, output, 2: header, aligned with o_rx_data.
- o_rx_valid, output, 1: output qualifier.
- o_block_lock, output, 1: block lock status.

## Operation
- A header is valid when it equals 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid. Only cycles with i_rx_valid=1 are evaluated; all counters hold while i_rx_valid=0.
- The FSM has four states:
  - LOCK_INIT: clear sh_cnt and sh_invld_cnt, deassert lock, go to TEST_SH.
  - TEST_SH (unlocked): an invalid header asserts o_rx_slip for 1 cycle, clears the counters and goes to SLIP_WAIT. A valid header increments sh_cnt; when sh_cnt reaches SH_LOCK_CNT, go to LOCKED and clear the counters.
  - SLIP_WAIT: ignore input for SLIP_WAIT cycles. The count runs on every i_clk, not only on valid cycles. Then go to TEST_SH.
  - LOCKED: o_block_lock=1. Every valid block increments sh_cnt, and every invalid header increments sh_invld_cnt.
    - If sh_invld_cnt reaches SH_INVLD_MAX: drop lock, pulse o_rx_slip, clear the counters and go to SLIP_WAIT. Lock drops in the cycle after the 16th invalid header is sampled.
    - Otherwise, when sh_cnt reaches SH_WINDOW: clear both counters and stay LOCKED.
    - If the 16th invalid header lands on the 1024th block, the unlock wins.
- Counter widths are $clog2(SH_WINDOW)+1 bits; no counter can wrap.
- Descrambler:
  - 58-bit shift state holding the most recent received scrambled bits.
  - out[i] = in[i] ^ s[i-39] ^ s[i-58], where s is the combined history of the state and the current word.
  - State updates on every valid block regardless of lock state, so descrambling is correct from the 2nd block after lock.
- o_rx_valid = registered i_rx_valid AND lock. Data and header from unlocked cycles are never presented as valid.

## Timing
- Latency: one i_clk from i_rx_valid/i_rx_data/i_rx_header to o_rx_valid/o_rx_data/o_rx_header.
- o_block_lock rises in the cycle after the 64th consecutive valid header is sampled.
- The block that completes lock is not presented; the first o_rx_valid corresponds to the following input block.
- o_rx_slip is registered, is high exactly 1 cycle, and at least SLIP_WAIT+1 cycles separate two pulses.
- Reset values: o_rx_slip=0, o_rx_data=0, o_rx_header=0, o_rx_valid=0, o_block_lock=0, descrambler state=0, FSM=LOCK_INIT.
- Reset asserted mid-operation clears everything asynchronously. After release, lock reacquisition needs the full 64 valid headers.

## Structure
- pcs_pkg holds:
  - SYNC_DATA = 2'b01, SYNC_CTRL = 2'b10.
  - Descrambler tap constants 39 and 58.
  - The lock FSM state enum.
  - Default values for SH_LOCK_CNT, SH_WINDOW, SH_INVLD_MAX and SLIP_WAIT.
- Sub-module pcs_rx_descrambler: 64-bit self-synchronizing descrambler with enable and active-low asynchronous reset. It mirrors the transmit scrambler.
- The top level holds the lock FSM, the counters and the output register stage.

## Test plan
- Reset release, then 64 scrambled idle blocks with header 2'b10 → o_block_lock=1 one cycle after block 64. o_rx_data equals the pre-scrambler idle pattern from block 66 onward. o_rx_slip never asserts.
- Header 2'b11 on block 30 while unlocked → o_rx_slip pulses once. Inputs are ignored for 32 cycles. Lock needs 64 fresh valid headers.
- Locked with 15 invalid headers spread within one 1024-block window → lock holds. A 16th invalid header within the same window → lock=0 and o_rx_slip pulses the next cycle.
- i_rx_valid low on every 33rd cycle (gearbox pause) → counters and descrambler freeze. Lock is still reached after exactly 64 valid blocks, and the data matches the golden model.
- Transmit-scrambler golden model, random payloads and headers for 2000 blocks after lock → bit-exact o_rx_data/o_rx_header with 1-cycle latency.
- i_reset_n pulsed low mid-frame while locked → all outputs 0 immediately. Relock after 64 valid blocks.
